// File: rtl/mul_outer_seq_if.sv
// Bus between mul_outer_seq, its upstream/downstream handshakes and the
// external partial-product unit. The master view is the sequencer itself;
// the slave view is everything around it.
interface mul_outer_seq_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
);
    logic                      i_valid;
    logic                      o_ready;
    logic [DEPTH-1:0]          o_idx;
    logic                      o_mul_en;
    logic                      o_mul_clr;
    logic signed [2*WIDTH-1:0] i_pp;
    logic                      o_valid;
    logic                      i_ready;
    logic signed [2*WIDTH-1:0] o_data;

    modport master (
        input  i_valid, i_pp, i_ready,
        output o_ready, o_idx, o_mul_en, o_mul_clr, o_valid, o_data
    );

    modport slave (
        output i_valid, i_pp, i_ready,
        input  o_ready, o_idx, o_mul_en, o_mul_clr, o_valid, o_data
    );
endinterface

// File: rtl/mul_outer_seq.sv
// mul_outer_seq: sequences a bit-serial signed multiply. Each RUN cycle
// issues one multiplier bit index to an external partial-product unit and,
// one enabled cycle later, folds the returned partial product into acc with
// its binary weight (the MSB weight is negative, two's complement).
// Optional feature macro: MUL_OUTER_ACC_EN -- when defined, acc is not
// cleared on accept, so o_data is a running sum of products.
module mul_outer_seq #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            clr,
    mul_outer_seq_if.master bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [DEPTH:0]   ICNT_MAX = (DEPTH+1)'(WIDTH);
    localparam logic [DEPTH-1:0] K_LAST   = DEPTH'(WIDTH - 1);

    state_t                    state;
    logic [DEPTH:0]            icnt;     // issue counter, saturates at WIDTH
    logic [DEPTH-1:0]          acnt;     // accumulate counter, bit weight k
    logic signed [2*WIDTH-1:0] acc;
    logic                      ready_q;
    logic                      valid_q;

    logic                      issuing;
    logic                      acc_step;
    logic signed [2*WIDTH-1:0] pp_sh;

    // An index is outstanding whenever issues lead accumulations; the
    // partial product for acnt is then present on i_pp.
    assign issuing  = (state == RUN) && (icnt < ICNT_MAX);
    assign acc_step = (state == RUN) && (icnt > {1'b0, acnt});
    assign pp_sh    = bus.i_pp <<< acnt;

    assign bus.o_ready   = ready_q;
    assign bus.o_valid   = valid_q;
    assign bus.o_idx     = issuing ? icnt[DEPTH-1:0] : '0;
    assign bus.o_mul_en  = issuing && en;
    assign bus.o_mul_clr = clr;
    assign bus.o_data    = acc;

    // FSM, counters, accumulator and registered handshake outputs.
    // NOTE: state is updated only with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            icnt    <= '0;
            acnt    <= '0;
            acc     <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else if (clr) begin
            state   <= IDLE;
            icnt    <= '0;
            acnt    <= '0;
            acc     <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (bus.i_valid && ready_q) begin
                        state   <= RUN;
                        ready_q <= 1'b0;
                        icnt    <= '0;
                        acnt    <= '0;
`ifndef MUL_OUTER_ACC_EN
                        acc     <= '0;
`endif
                    end
                end
                RUN: begin
                    if (issuing)
                        icnt <= icnt + 1'b1;
                    if (acc_step) begin
                        acnt <= acnt + 1'b1;
                        if (acnt == K_LAST) begin
                            acc     <= acc - pp_sh;
                            state   <= DONE;
                            valid_q <= 1'b1;
                        end else begin
                            acc <= acc + pp_sh;
                        end
                    end
                end
                DONE: begin
                    if (bus.i_ready) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_outer_seq.sv
// Bench for mul_outer_seq (WIDTH=8) with a behavioural partial-product unit
// attached and a reference model computing products with plain arithmetic.
module tb_mul_outer_seq;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1;
    logic clr = 1'b0;

    logic signed [WIDTH-1:0]   op_a = '0;
    logic signed [WIDTH-1:0]   op_b = '0;
    logic [DEPTH-1:0]          pp_idx;
    logic signed [2*WIDTH-1:0] ref_acc = '0;

    int n_cmp = 0;
    int n_err = 0;

    mul_outer_seq_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    mul_outer_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (clr),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Partial-product unit: latches the index, returns a * b[idx].
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)             pp_idx <= '0;
        else if (bus.o_mul_clr) pp_idx <= '0;
        else if (bus.o_mul_en)  pp_idx <= bus.o_idx;
    end
    assign bus.i_pp = op_b[pp_idx] ? {{WIDTH{op_a[WIDTH-1]}}, op_a} : '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: product (or running sum) by plain integer arithmetic.
    task automatic model_op(input logic signed [WIDTH-1:0] a, input logic signed [WIDTH-1:0] b);
        longint p;
        p = longint'(a) * longint'(b);
`ifdef MUL_OUTER_ACC_EN
        ref_acc = 16'(longint'(ref_acc) + p);
`else
        ref_acc = 16'(p);
`endif
    endtask

    // One full multiply: optional en stall of stall_len cycles starting at
    // RUN cycle stall_at (0..8), and hold cycles of i_ready=0 in DONE.
    task automatic do_op(input logic signed [WIDTH-1:0] a, input logic signed [WIDTH-1:0] b,
                         input int stall_at, input int stall_len, input int hold);
        int edges;
        int issued;
        bit stall;
        @(negedge clk);
        op_a = a; op_b = b; bus.i_valid = 1'b1; en = 1'b1; bus.i_ready = 1'b0;
        check("ready_before_accept", bus.o_ready, 1);
        model_op(a, b);
        @(posedge clk);
        edges = 0; issued = 0;
        while (edges < 64) begin
            @(negedge clk);
            bus.i_valid = 1'b0;
            if (bus.o_valid) break;
            stall = (edges >= stall_at) && (edges < stall_at + stall_len);
            en = !stall;
            #1;
            check("ready_low_busy", bus.o_ready, 0);
            if (issued < WIDTH) begin
                check("idx", bus.o_idx, issued);
                check("mul_en", bus.o_mul_en, !stall);
                if (!stall) issued++;
            end else begin
                check("mul_en_after_issue", bus.o_mul_en, 0);
            end
            @(posedge clk);
            edges++;
        end
        en = 1'b1;
        check("latency", edges, WIDTH + 1 + stall_len);
        check("data", bus.o_data, ref_acc);
        check("ready_low_done", bus.o_ready, 0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", bus.o_valid, 1);
            check("hold_data", bus.o_data, ref_acc);
        end
        bus.i_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_ready = 1'b0;
        check("handoff_valid", bus.o_valid, 0);
        check("handoff_ready", bus.o_ready, 1);
        check("idle_data", bus.o_data, ref_acc);
        check("idle_idx", bus.o_idx, 0);
        check("idle_mul_en", bus.o_mul_en, 0);
    endtask

    // Start a multiply and kill it after n RUN edges via clr or reset.
    task automatic do_abort(input logic signed [WIDTH-1:0] a, input logic signed [WIDTH-1:0] b,
                            input int n, input bit use_reset);
        bit seen_valid;
        @(negedge clk);
        op_a = a; op_b = b; bus.i_valid = 1'b1; en = 1'b1;
        @(posedge clk);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.i_valid = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        if (use_reset) begin
            rst_n = 1'b0;
            #1;
            check("rst_valid", bus.o_valid, 0);
            check("rst_data", bus.o_data, 0);
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            clr = 1'b1;
            #1;
            check("mul_clr", bus.o_mul_clr, 1);
            @(posedge clk);
            @(negedge clk);
            clr = 1'b0;
        end
        ref_acc = '0;
        check("abort_ready", bus.o_ready, 1);
        check("abort_data", bus.o_data, 0);
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.o_valid) seen_valid = 1'b1;
        end
        check("abort_no_valid", seen_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        #12;
        check("reset_ready", bus.o_ready, 1);
        check("reset_valid", bus.o_valid, 0);
        check("reset_data", bus.o_data, 0);
        check("reset_idx", bus.o_idx, 0);
        check("reset_mul_en", bus.o_mul_en, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // en=0 blocks acceptance.
        @(negedge clk);
        en = 1'b0; bus.i_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("en0_no_accept", bus.o_ready, 1);
        bus.i_valid = 1'b0; en = 1'b1;

        do_op(8'sd3, 8'sd5, 0, 0, 0);
        do_op(-8'sd128, -8'sd128, 0, 0, 0);
        do_op(8'sd127, -8'sd1, 0, 0, 0);
        do_op(8'sd3, 8'sd5, 3, 4, 0);
        do_abort(8'sd7, 8'sd9, 3, 1'b0);
        do_op(8'sd2, 8'sd7, 0, 0, 0);
        do_op(8'sd3, 8'sd5, 0, 0, 5);
        do_abort(-8'sd50, 8'sd77, 4, 1'b1);
        do_op(8'sd1, 8'sd1, 0, 0, 0);

        for (int i = 0; i < 16; i++)
            do_op(WIDTH'($urandom), WIDTH'($urandom), $urandom_range(0, 8),
                  $urandom_range(0, 3), $urandom_range(0, 2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mul_outer_seq.md
MUL_OUTER_SEQ -- requirements
Module: mul_outer_seq

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning the operand width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 3, meaning the bit-index width, equal to clog2(WIDTH).
REQ-003 clk  input  1  Single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  Asynchronous reset, active-low.
REQ-005 en  input  1  Global advance enable; low freezes all state.
REQ-006 clr  input  1  Synchronous abort and clear.
REQ-007 i_valid  input  1  Upstream requests a multiply; operands are held stable at the partial-product unit until o_valid is accepted.
REQ-008 o_ready  output  1  Request acceptance.
REQ-009 o_idx  output  DEPTH  Multiplier bit index driven to the partial-product unit.
REQ-010 o_mul_en  output  1  Index-latch enable for the partial-product unit.
REQ-011 o_mul_clr  output  1  Index clear for the partial-product unit; equals clr.
REQ-012 i_pp  input  signed 2*WIDTH  Partial product for the index latched on the previous edge.
REQ-013 o_valid  output  1  Product available.
REQ-014 i_ready  input  1  Downstream accepts the product.
REQ-015 o_data  output  signed 2*WIDTH  Signed product, or the accumulated sum (see Configuration).

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE; o_ready SHALL be 1 only in IDLE and o_valid SHALL be 1 only in DONE.
REQ-017 IDLE->RUN SHALL occur on an edge with en=1, i_valid=1 and o_ready=1; issue counter and accumulate counter SHALL both load 0.
REQ-018 In RUN, o_idx SHALL equal the issue counter and o_mul_en SHALL equal en while issue count < WIDTH; the issue counter SHALL increment on each en=1 edge, saturating at WIDTH.
REQ-019 In RUN, accumulation SHALL start one en-cycle after the first issue; acc SHALL add (i_pp << k) for k = 0..WIDTH-2 and subtract (i_pp << (WIDTH-1)) for k = WIDTH-1 (two's-complement MSB weight), all modulo 2^(2*WIDTH).
REQ-020 RUN->DONE SHALL occur on the edge that accumulates k = WIDTH-1; with en held high, o_valid SHALL rise WIDTH+1 edges after the accept edge.
REQ-021 DONE->IDLE SHALL occur on an edge with en=1 and i_ready=1; o_data SHALL hold stable in DONE and IDLE.
REQ-022 A request cannot be accepted on the same edge as a product handoff; there SHALL be one IDLE cycle between products.
REQ-023 With en=0, state, counters and acc SHALL hold, o_mul_en SHALL be 0, and no handshake SHALL complete.
REQ-024 clr=1 SHALL take priority over en and handshakes: next state IDLE, counters 0, and acc 0.
REQ-025 Outside RUN, o_idx SHALL be 0 and o_mul_en SHALL be 0.

Reset
REQ-026 On rst_n=0 the module SHALL asynchronously enter IDLE, with the counters, acc and o_data at 0, o_idx=0, o_mul_en=0, o_valid=0 and o_ready=1 (after release).
REQ-027 Reset mid-RUN SHALL discard the partial result with no o_valid pulse.

Configuration
REQ-028 With macro MUL_OUTER_ACC_EN defined, acc SHALL NOT clear on IDLE->RUN, so o_data is the running sum of products since the last clr or reset, wrapping modulo 2^(2*WIDTH).
REQ-029 Without MUL_OUTER_ACC_EN, acc SHALL clear on every IDLE->RUN, so o_data equals the single product.

Verification (WIDTH=8 with a real partial-product unit attached; en=1 unless stated)
REQ-030 Operands 3*5, i_ready=1 -> o_idx steps 0..7, o_valid rises 9 edges after accept, and o_data=15.
REQ-031 Operands -128*-128 and then 127*-1 -> o_data=16384, then -127; o_ready is low through RUN and DONE.
REQ-032 Operands 3*5 with en=0 for 4 cycles mid-RUN -> o_idx holds and o_mul_en=0 during the stall, o_valid rises 13 edges after accept, and o_data=15.
REQ-033 clr pulsed at the 4th RUN edge -> IDLE on the next edge, no o_valid, and the next request 2*7 yields 14.
REQ-034 i_ready=0 for 5 cycles in DONE -> o_valid and o_data hold, and the product is accepted on the first en=1, i_ready=1 edge.
REQ-035 With MUL_OUTER_ACC_EN: 3*5, then 2*7 -> o_data=15, then 29; after clr, 1*1 -> 1.
